// File: rtl/dmem_wait_if.sv
// dmem_wait_if: request/response bus between a requester and the dmem_wait data memory
interface dmem_wait_if;
  logic req, we, sext, ready, done, fault;
  logic [1:0] size;
  logic [31:0] a, wd, rd;
  modport master(output req, we, size, sext, a, wd, input ready, done, rd, fault);
  modport slave(input req, we, size, sext, a, wd, output ready, done, rd, fault);
endinterface

// File: rtl/dmem_wait.sv
// dmem_wait: single-port byte/half/word data memory with programmable wait states
module dmem_wait #(
  parameter int DEPTH = 64,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic reset,
  dmem_wait_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_wait: LATENCY must be 0..15");
  end
  if (DEPTH < 4 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("dmem_wait: DEPTH must be a power of 2 and >= 4");
  end
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [3:0] cnt;
  logic c_we, c_sext;
  logic [1:0] c_size;
  logic [31:0] c_a, c_wd;
  logic u_we, u_sext;
  logic [1:0] u_size;
  logic [31:0] u_a, u_wd;
  logic go, flt;
  logic [AW-1:0] idx;
  logic [31:0] word, ld, wdata;
  logic [3:0] wmask;
  logic [7:0] b;
  logic [15:0] h;
  logic [31:0] mem [DEPTH];
  // With zero wait states the access completes on the accept edge using the live inputs.
  always_comb begin
    u_we = state == IDLE ? bus.we : c_we;
    u_sext = state == IDLE ? bus.sext : c_sext;
    u_size = state == IDLE ? bus.size : c_size;
    u_a = state == IDLE ? bus.a : c_a;
    u_wd = state == IDLE ? bus.wd : c_wd;
    go = state == IDLE ? bus.req && LATENCY == 0 : cnt == 4'd1;
    flt = (&u_size) | (u_size == 2'd1 && u_a[0]) | (u_size == 2'd2 && |u_a[1:0]) | (|u_a[31:AW+2]);
    idx = u_a[AW+1:2];
    word = mem[idx];
    b = word[{u_a[1:0], 3'b000} +: 8];
    h = u_a[1] ? word[31:16] : word[15:0];
    ld = u_size == 2'd0 ? {{24{u_sext & b[7]}}, b} : u_size == 2'd1 ? {{16{u_sext & h[15]}}, h} : word;
    wmask = u_size == 2'd0 ? 4'b0001 << u_a[1:0] : u_size == 2'd1 ? {{2{u_a[1]}}, {2{~u_a[1]}}} : 4'hf;
    wdata = u_size == 2'd0 ? {4{u_wd[7:0]}} : u_size == 2'd1 ? {2{u_wd[15:0]}} : u_wd;
  end
  assign bus.ready = state == IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bus.done <= 1'b0;
      bus.fault <= 1'b0;
      bus.rd <= '0;
    end else begin
      bus.done <= go;
      bus.fault <= go & flt;
      if (go && !u_we) bus.rd <= flt ? '0 : ld;
      if (state == IDLE) begin
        if (bus.req && LATENCY != 0) begin
          state <= BUSY;
          cnt <= 4'(LATENCY);
          c_we <= bus.we;
          c_sext <= bus.sext;
          c_size <= bus.size;
          c_a <= bus.a;
          c_wd <= bus.wd;
        end
      end else begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) state <= IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (go && u_we && !flt && !reset)
      for (int k = 0; k < 4; k++)
        if (wmask[k]) mem[idx][8*k +: 8] <= wdata[8*k +: 8];
  end
endmodule

// File: tb/tb_dmem_wait.sv
// tb_dmem_wait: three dmem_wait instances (LATENCY 0/2/3) on shared stimulus vs a byte-array model
module tb_dmem_wait;
  typedef struct {logic we; logic [1:0] size; logic sext; logic [31:0] a, wd;} op_t;
  logic clk = 0, reset = 1, req = 0, we = 0, sext = 0;
  logic [1:0] size = 0;
  logic [31:0] a = 0, wd = 0;
  logic ready_d [3], done_d [3], fault_d [3];
  logic [31:0] rd_d [3];
  int vectors = 0, miscompares = 0;
  bit busy_m [3], done_m [3], fault_m [3];
  int rem_m [3];
  op_t pend [3];
  logic [7:0] mem_m [3][256];
  logic [31:0] rd_m [3];
  int last_lat [3];
  logic last_fault [3];
  logic [31:0] last_rd [3];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_wait_if bus ();
    assign bus.req = req;
    assign bus.we = we;
    assign bus.size = size;
    assign bus.sext = sext;
    assign bus.a = a;
    assign bus.wd = wd;
    assign ready_d[g] = bus.ready;
    assign done_d[g] = bus.done;
    assign fault_d[g] = bus.fault;
    assign rd_d[g] = bus.rd;
    dmem_wait #(.DEPTH(64), .LATENCY(g == 0 ? 0 : g + 1)) u_dut (.clk(clk), .reset(reset), .bus(bus.slave));
  end
  function automatic int lat_of(int k);
    return k == 0 ? 0 : k + 1;
  endfunction
  task automatic chk(input string n, input int k, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s [LATENCY=%0d] at %0t: got %h expected %h", n, lat_of(k), $time, act, exp);
    end
  endtask
  task automatic perform(input int k, input op_t o);
    bit f;
    int nb;
    logic [31:0] v;
    f = o.size == 2'd3 || (o.size == 2'd1 && o.a[0]) || (o.size == 2'd2 && o.a[1:0] != 0) || o.a[31:2] >= 64;
    nb = 1 << o.size;
    done_m[k] = 1;
    fault_m[k] = f;
    if (o.we) begin
      if (!f) for (int i = 0; i < nb; i++) mem_m[k][int'(o.a[7:0]) + i] = o.wd[8*i +: 8];
    end else if (f) rd_m[k] = 0;
    else begin
      v = 0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = mem_m[k][int'(o.a[7:0]) + i];
      if (o.sext && nb < 4 && v[8*nb-1]) v = v | (32'hFFFFFFFF << (8*nb));
      rd_m[k] = v;
    end
  endtask
  // Advance the model across the coming edge, then check every instance just after it.
  task automatic step();
    op_t cur;
    cur.we = we; cur.size = size; cur.sext = sext; cur.a = a; cur.wd = wd;
    for (int k = 0; k < 3; k++) begin
      done_m[k] = 0;
      fault_m[k] = 0;
      if (reset) begin
        busy_m[k] = 0;
        rd_m[k] = 0;
      end else if (busy_m[k]) begin
        rem_m[k]--;
        if (rem_m[k] == 0) begin
          busy_m[k] = 0;
          perform(k, pend[k]);
        end
      end else if (req) begin
        if (lat_of(k) == 0) perform(k, cur);
        else begin
          busy_m[k] = 1;
          rem_m[k] = lat_of(k);
          pend[k] = cur;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("ready", k, 32'(ready_d[k]), 32'(!busy_m[k]));
      chk("done", k, 32'(done_d[k]), 32'(done_m[k]));
      chk("fault", k, 32'(fault_d[k]), 32'(fault_m[k]));
      chk("rd", k, rd_d[k], rd_m[k]);
    end
  endtask
  task automatic issue(input logic w, input logic [1:0] s, input logic x, input logic [31:0] ad, input logic [31:0] d);
    we = w; size = s; sext = x; a = ad; wd = d; req = 1;
    for (int k = 0; k < 3; k++) last_lat[k] = 0;
    for (int c = 1; c <= 5; c++) begin
      step();
      req = 0;
      for (int k = 0; k < 3; k++)
        if (done_d[k] === 1'b1 && last_lat[k] == 0) begin
          last_lat[k] = c;
          last_fault[k] = fault_d[k];
          last_rd[k] = rd_d[k];
        end
    end
  endtask
  initial begin
    int nd;
    logic [31:0] d;
    for (int k = 0; k < 3; k++) for (int i = 0; i < 256; i++) mem_m[k][i] = 8'h00;
    step();
    step();
    for (int k = 0; k < 3; k++) chk("reset_ready", k, 32'(ready_d[k]), 32'd1);
    reset = 0;
    for (int i = 0; i < 64; i++) issue(1, 2'd2, 0, 32'(4 * i), 32'h0);
    issue(1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
    chk("t1_store_lat", 1, 32'(last_lat[1]), 32'd3);
    issue(0, 2'd2, 0, 32'h10, 32'h0);
    chk("t1_load_lat", 1, 32'(last_lat[1]), 32'd3);
    chk("t1_lat_l0", 0, 32'(last_lat[0]), 32'd1);
    chk("t1_lat_l3", 2, 32'(last_lat[2]), 32'd4);
    chk("t1_rd", 1, last_rd[1], 32'hDEADBEEF);
    chk("t1_fault", 1, 32'(last_fault[1]), 32'd0);
    issue(1, 2'd2, 0, 32'h10, 32'h0);
    issue(1, 2'd0, 0, 32'h13, 32'h000000A5);
    issue(0, 2'd0, 1, 32'h13, 32'h0);
    for (int k = 0; k < 3; k++) chk("t2_lb_sext", k, last_rd[k], 32'hFFFFFFA5);
    issue(0, 2'd0, 0, 32'h13, 32'h0);
    chk("t2_lb_zext", 1, last_rd[1], 32'h000000A5);
    issue(0, 2'd2, 0, 32'h10, 32'h0);
    chk("t2_lw", 1, last_rd[1], 32'hA5000000);
    issue(0, 2'd1, 1, 32'h11, 32'h0);
    chk("t3_half_mis_fault", 1, 32'(last_fault[1]), 32'd1);
    chk("t3_half_mis_rd", 1, last_rd[1], 32'h0);
    issue(0, 2'd2, 0, 32'h100, 32'h0);
    chk("t3_range_fault", 1, 32'(last_fault[1]), 32'd1);
    issue(1, 2'd2, 0, 32'h100, 32'hFFFFFFFF);
    issue(0, 2'd3, 0, 32'h10, 32'h0);
    chk("t3_size11_fault", 1, 32'(last_fault[1]), 32'd1);
    issue(0, 2'd2, 0, 32'h0, 32'h0);
    chk("t3_no_alias", 1, last_rd[1], 32'h0);
    issue(0, 2'd2, 0, 32'h10, 32'h0);
    chk("t3_unchanged", 1, last_rd[1], 32'hA5000000);
    req = 1;
    for (int i = 0; i < 10; i++) begin
      d = $urandom;
      we = 1; size = 2'd2; a = 32'(32'h40 + 4 * i); wd = d;
      step();
      we = 0;
      step();
      chk("t4_done", 0, 32'(done_d[0]), 32'd1);
      chk("t4_rd", 0, rd_d[0], d);
    end
    req = 0;
    repeat (5) step();
    issue(1, 2'd2, 0, 32'h20, 32'hCAFEF00D);
    we = 1; size = 2'd2; a = 32'h20; wd = 32'h12345678; req = 1;
    step();
    req = 0; reset = 1;
    step();
    reset = 0;
    chk("t5_ready", 1, 32'(ready_d[1]), 32'd1);
    chk("t5_no_done", 1, 32'(done_d[1]), 32'd0);
    repeat (4) step();
    issue(0, 2'd2, 0, 32'h20, 32'h0);
    chk("t5_old_l2", 1, last_rd[1], 32'hCAFEF00D);
    chk("t5_old_l3", 2, last_rd[2], 32'hCAFEF00D);
    chk("t5_new_l0", 0, last_rd[0], 32'h12345678);
    nd = 0;
    we = 0; size = 2'd2; a = 32'h10; req = 1;
    step();
    nd += int'(done_d[2]);
    we = 1; wd = 32'h00000BAD;
    for (int c = 0; c < 4; c++) begin
      req = c < 2;
      step();
      nd += int'(done_d[2]);
    end
    chk("t6_one_done", 2, 32'(nd), 32'd1);
    issue(0, 2'd2, 0, 32'h10, 32'h0);
    chk("t6_ignored_l3", 2, last_rd[2], 32'hA5000000);
    chk("t6_accepted_l0", 0, last_rd[0], 32'h00000BAD);
    for (int i = 0; i < 3000; i++) begin
      req = $urandom_range(0, 3) != 0;
      we = 1'($urandom);
      size = 2'($urandom);
      sext = 1'($urandom);
      a = $urandom_range(0, 15) == 0 ? $urandom : 32'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << size) - 32'd1);
      wd = $urandom;
      reset = $urandom_range(0, 63) == 0;
      step();
    end
    reset = 0; req = 0;
    repeat (6) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
